// File: rtl/bus_arbiter_pkg.sv
// bus_arbiter_pkg
// Shared definitions for the system bus arbiter: FSM state encoding,
// default timeout values and the width of the transaction counters.
package bus_arbiter_pkg;

  localparam int CNT_W              = 16;
  localparam int DEF_NUM_MASTERS    = 4;
  localparam int DEF_BEGIN_TIMEOUT  = 16;
  localparam int DEF_ACTIVE_TIMEOUT = 1024;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GRANT,
    ST_WAIT_BEGIN,
    ST_ACTIVE,
    ST_RELEASE
  } arb_state_e;

endpackage

// File: rtl/rr_picker.sv
// rr_picker
// Combinational round-robin winner selection. Searches request upward from
// prio_ptr, wrapping at NUM_MASTERS, and returns the first set bit.
// Ports:
//   request  - per-master request vector
//   prio_ptr - index with highest priority this round
//   winner   - selected master index (only meaningful when any_req is set)
//   any_req  - at least one request bit is set
module rr_picker #(
  parameter int NUM_MASTERS = 4,
  localparam int IDX_W = $clog2(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] request,
  input  logic [IDX_W-1:0]       prio_ptr,
  output logic [IDX_W-1:0]       winner,
  output logic                   any_req
);

  localparam logic [IDX_W:0] NUM_M = (IDX_W+1)'(NUM_MASTERS);

  logic [2*NUM_MASTERS-1:0] req_dbl;
  logic [NUM_MASTERS-1:0]   req_rot;
  logic [IDX_W-1:0]         offset;
  logic [IDX_W:0]           sum;

  always_comb begin
    any_req = |request;
    // Rotating a doubled copy puts prio_ptr at bit 0, so the lowest set bit
    // of req_rot is the distance from prio_ptr to the winner.
    req_dbl = {request, request};
    req_rot = NUM_MASTERS'(req_dbl >> prio_ptr);
    offset  = '0;
    for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
      if (req_rot[k]) offset = IDX_W'(k);
    end
    sum    = {1'b0, prio_ptr} + {1'b0, offset};
    winner = (sum >= NUM_M) ? IDX_W'(sum - NUM_M) : IDX_W'(sum);
  end

endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter
// Round-robin arbiter for the shared system bus with begin/active watchdogs.
// Ports:
//   clock, reset          - system clock, synchronous active-high reset
//   request               - per-master level requests
//   granted               - one-hot, one-cycle grant pulse
//   begin_transaction_in  - owner starts its transaction
//   end_transaction_in    - transaction end from slave or owner
//   error_in              - bus error from slave
//   end_transaction_out   - arbiter-forced end pulse (watchdog)
//   error_out             - arbiter-forced error pulse, same cycle as end
//   bus_owner             - index of the most recently granted master
//   bus_active            - high from GRANT until RELEASE completes
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS    = DEF_NUM_MASTERS,
  parameter int BEGIN_TIMEOUT  = DEF_BEGIN_TIMEOUT,
  parameter int ACTIVE_TIMEOUT = DEF_ACTIVE_TIMEOUT,
  localparam int IDX_W = $clog2(NUM_MASTERS)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_MASTERS-1:0] request,
  output logic [NUM_MASTERS-1:0] granted,
  input  logic                   begin_transaction_in,
  input  logic                   end_transaction_in,
  input  logic                   error_in,
  output logic                   end_transaction_out,
  output logic                   error_out,
  output logic [IDX_W-1:0]       bus_owner,
  output logic                   bus_active
);

  // WAIT_BEGIN lasts exactly BEGIN_TIMEOUT cycles (counter 0..BEGIN_TIMEOUT-1).
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(BEGIN_TIMEOUT - 1);
  // The begin cycle itself and the forced-pulse output register each take
  // one cycle, so the watchdog decides two counts early to land the pulse
  // exactly ACTIVE_TIMEOUT cycles after the begin cycle.
  localparam logic [CNT_W-1:0] WD_LAST   = CNT_W'(ACTIVE_TIMEOUT - 2);

  arb_state_e             state, state_next;
  logic [IDX_W-1:0]       prio_ptr;
  logic [IDX_W-1:0]       winner;
  logic [IDX_W-1:0]       grant_idx;
  logic                   any_req;
  logic [CNT_W-1:0]       wait_cnt;
  logic [CNT_W-1:0]       wd_cnt;
  logic                   wait_expire;
  logic                   wd_expire;
  logic                   ext_term;
  logic                   force_next;
  logic [NUM_MASTERS-1:0] grant_next;

  function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] w);
    return (w == IDX_W'(NUM_MASTERS - 1)) ? '0 : w + 1'b1;
  endfunction

  rr_picker #(
    .NUM_MASTERS (NUM_MASTERS)
  ) u_picker (
    .request  (request),
    .prio_ptr (prio_ptr),
    .winner   (winner),
    .any_req  (any_req)
  );

  assign wait_expire = (wait_cnt == WAIT_LAST);
  assign wd_expire   = (wd_cnt == WD_LAST);
  // End and error together are one termination.
  assign ext_term    = end_transaction_in | error_in;

  always_comb begin
    state_next = state;
    force_next = 1'b0;
    grant_next = '0;
    case (state)
      ST_IDLE: begin
        if (any_req) state_next = ST_GRANT;
      end
      ST_GRANT: begin
        grant_next[grant_idx] = 1'b1;
        state_next            = ST_WAIT_BEGIN;
      end
      ST_WAIT_BEGIN: begin
        // A begin in the final waiting cycle still wins over the timeout.
        if (begin_transaction_in) state_next = ST_ACTIVE;
        else if (wait_expire)     state_next = ST_RELEASE;
      end
      ST_ACTIVE: begin
        if (ext_term) begin
          state_next = ST_RELEASE;
        end else if (wd_expire) begin
          state_next = ST_RELEASE;
          force_next = 1'b1;
        end
      end
      ST_RELEASE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state               <= ST_IDLE;
      prio_ptr            <= '0;
      granted             <= '0;
      end_transaction_out <= 1'b0;
      error_out           <= 1'b0;
      bus_owner           <= '0;
      bus_active          <= 1'b0;
      wait_cnt            <= '0;
      wd_cnt              <= '0;
    end else begin
      state               <= state_next;
      granted             <= grant_next;
      end_transaction_out <= force_next;
      error_out           <= force_next;
      bus_active          <= (state_next != ST_IDLE);
      if (state == ST_IDLE && any_req) prio_ptr <= next_ptr(winner);
      if (state == ST_GRANT) bus_owner <= grant_idx;
      // Counters sit at zero outside their state, so entry always starts at 0.
      wait_cnt <= (state == ST_WAIT_BEGIN) ? wait_cnt + 1'b1 : '0;
      wd_cnt   <= (state == ST_ACTIVE)     ? wd_cnt + 1'b1   : '0;
    end
  end

  // Winner is frozen at the IDLE decision; later request changes are ignored.
  always_ff @(posedge clock) begin
    if (state == ST_IDLE) grant_idx <= winner;
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter
// Self-checking bench for bus_arbiter (4 masters, BEGIN_TIMEOUT=16,
// ACTIVE_TIMEOUT=20). Inputs are driven and outputs sampled on the falling
// edge. Transaction outcomes come from a transaction-level model: winner by
// modular search from the round-robin pointer, and the cycle offsets of the
// forced pulse and bus release derived from begin/end timing.
module tb_bus_arbiter;

  localparam int N  = 4;
  localparam int BT = 16;
  localparam int T  = 20;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] request = '0;
  logic [N-1:0] granted;
  logic         begin_transaction_in = 1'b0;
  logic         end_transaction_in = 1'b0;
  logic         error_in = 1'b0;
  logic         end_transaction_out;
  logic         error_out;
  logic [1:0]   bus_owner;
  logic         bus_active;

  int n_checks = 0;
  int n_fail   = 0;
  int mptr     = 0;

  typedef struct {
    logic [N-1:0] req;
    int           exp_w;
    int           bd;
    int           d;
  } vec_t;

  vec_t tbl[11];

  always #5 clock = ~clock;

  bus_arbiter #(
    .NUM_MASTERS    (N),
    .BEGIN_TIMEOUT  (BT),
    .ACTIVE_TIMEOUT (T)
  ) dut (
    .clock                (clock),
    .reset                (reset),
    .request              (request),
    .granted              (granted),
    .begin_transaction_in (begin_transaction_in),
    .end_transaction_in   (end_transaction_in),
    .error_in             (error_in),
    .end_transaction_out  (end_transaction_out),
    .error_out            (error_out),
    .bus_owner            (bus_owner),
    .bus_active           (bus_active)
  );

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int model_pick(input logic [N-1:0] req, input int ptr);
    int c;
    for (int i = 0; i < N; i++) begin
      c = (ptr + i) % N;
      if (req[c[1:0]]) return c;
    end
    return -1;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, ".granted"},    int'(granted), 0);
    check({tag, ".end_out"},    int'(end_transaction_out), 0);
    check({tag, ".error_out"},  int'(error_out), 0);
    check({tag, ".bus_owner"},  int'(bus_owner), 0);
    check({tag, ".bus_active"}, int'(bus_active), 0);
  endtask

  // Request is dropped after the first edge (DUT already in GRANT).
  task automatic wait_grant(input logic [N-1:0] req, input int exp_w, input string tag);
    int lat;
    lat = 0;
    request = req;
    do begin
      tick();
      lat++;
      if (lat == 1) request = '0;
    end while (granted == '0 && lat < 10);
    check({tag, ".grant_latency"}, lat, 2);
    check({tag, ".granted"}, int'(granted), 1 << exp_w);
    check({tag, ".bus_owner"}, int'(bus_owner), exp_w);
  endtask

  // bd: cycles after the grant pulse sample at which begin is driven
  // (negative = never). d: cycles after begin at which the termination
  // selected by term (bit0 end, bit1 error) is driven.
  task automatic txn(input logic [N-1:0] req, input int exp_w, input int bd,
                     input int d, input logic [1:0] term, input string tag);
    int fall, last, pulse_j;
    wait_grant(req, exp_w, tag);
    pulse_j = (bd >= 0 && d >= T) ? bd + T : -1;
    if (bd < 0) begin
      fall = BT + 1;
      last = fall;
    end else begin
      fall = bd + ((d < T - 1) ? d : T - 1) + 2;
      last = (bd + d > fall) ? bd + d : fall;
    end
    for (int j = 0; j <= last; j++) begin
      if (j > 0) check({tag, ".grant_width"}, int'(granted), 0);
      check({tag, ".end_out"},    int'(end_transaction_out), int'(j == pulse_j));
      check({tag, ".error_out"},  int'(error_out), int'(j == pulse_j));
      check({tag, ".bus_active"}, int'(bus_active), int'(j < fall));
      begin_transaction_in = (bd >= 0 && j == bd);
      end_transaction_in   = term[0] && bd >= 0 && j == bd + d;
      error_in             = term[1] && bd >= 0 && j == bd + d;
      if (j < last) tick();
    end
    begin_transaction_in = 1'b0;
    end_transaction_in   = 1'b0;
    error_in             = 1'b0;
    mptr = (exp_w + 1) % N;
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish, %0d checks, %0d failures",
             n_checks, n_fail);
    $fatal(1, "timeout");
  end

  initial begin
    logic [N-1:0] rreq;
    int           w, bd, d, r;
    logic [1:0]   term;

    // Expected winners hand-derived from the round-robin rule, pointer 0 at start.
    tbl[0]  = '{4'b0001, 0, 1, 8};
    tbl[1]  = '{4'b1111, 1, 1, 1};
    tbl[2]  = '{4'b1111, 2, 0, 1};
    tbl[3]  = '{4'b1111, 3, 1, 1};
    tbl[4]  = '{4'b1111, 0, 0, 1};
    tbl[5]  = '{4'b0001, 0, 1, 1};
    tbl[6]  = '{4'b1001, 3, 1, 2};
    tbl[7]  = '{4'b0110, 1, 0, 1};
    tbl[8]  = '{4'b0010, 1, 2, 3};
    tbl[9]  = '{4'b1100, 2, 1, 1};
    tbl[10] = '{4'b0101, 0, 0, 1};

    // Reset state
    reset = 1'b1;
    tick();
    check_all_zero("reset");
    tick();
    reset = 1'b0;
    tick();
    check("idle_no_req.bus_active", int'(bus_active), 0);

    // Table: single master, contention ordering, mixed masks
    for (int i = 0; i < 11; i++) begin
      txn(tbl[i].req, tbl[i].exp_w, tbl[i].bd, tbl[i].d, 2'b01, $sformatf("tbl%0d", i));
    end

    // Begin timeout for master 2, then the next requester gets the bus
    txn(4'b0100, 2, -1, 0, 2'b00, "begin_timeout");
    txn(4'b1010, 3, 0, 1, 2'b01, "after_timeout");

    // Watchdog expiry, then error_in in the expiry cycle suppresses it
    txn(4'b0010, 1, 1, T + 1, 2'b01, "watchdog");
    txn(4'b0001, 0, 0, T - 1, 2'b10, "wd_vs_error");

    // Reset in the middle of ACTIVE
    wait_grant(4'b0010, 1, "rst_mid");
    tick();
    begin_transaction_in = 1'b1;
    tick();
    begin_transaction_in = 1'b0;
    tick();
    tick();
    check("rst_mid.pre_active", int'(bus_active), 1);
    reset = 1'b1;
    tick();
    check_all_zero("rst_mid");
    reset = 1'b0;
    mptr = 0;
    txn(4'b0110, 1, 0, 1, 2'b01, "post_reset_ptr");
    txn(4'b1000, 3, 1, 1, 2'b11, "post_reset_m3");

    // Randomized transactions against the model
    for (int i = 0; i < 40; i++) begin
      rreq = N'($urandom_range(1, 15));
      w = model_pick(rreq, mptr);
      r = $urandom_range(0, 9);
      if (r == 0)      bd = -1;
      else if (r == 1) bd = BT - 1;
      else             bd = $urandom_range(0, 3);
      r = $urandom_range(0, 9);
      if (r == 0)      d = T + $urandom_range(0, 1);
      else if (r == 1) d = T - 1;
      else             d = $urandom_range(1, 6);
      term = 2'($urandom_range(1, 3));
      txn(rreq, w, bd, d, term, $sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
